// File: rtl/timer_multi.sv
// Multi-channel down-counter timer: per-channel one-shot/periodic reload,
// registered expiry trigger and sticky interrupt, shared load port.
module timer_multi #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_BITS  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         enable,
  input  logic                        wr_valid,
  input  logic [CH_BITS-1:0]          wr_ch,
  input  logic [WIDTH-1:0]            wr_value,
  input  logic                        wr_periodic,
  input  logic [CHANNELS-1:0]         irq_clear,
  output logic [CHANNELS-1:0]         trigger,
  output logic [CHANNELS-1:0]         irq,
  output logic [CHANNELS-1:0]         busy,
  output logic [CHANNELS*WIDTH-1:0]   count_flat
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t              state_q  [CHANNELS];
  state_t              state_d  [CHANNELS];
  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    count_d  [CHANNELS];
  logic [WIDTH-1:0]    reload_q [CHANNELS];
  logic [WIDTH-1:0]    reload_d [CHANNELS];
  logic [CHANNELS-1:0] periodic_q, periodic_d;
  logic [CHANNELS-1:0] trigger_q, trigger_d;
  logic [CHANNELS-1:0] irq_q, irq_d;
  logic [CHANNELS-1:0] wr_hit;

  // Addresses at or beyond CHANNELS match no channel, so such writes vanish.
  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr_valid && (32'(wr_ch) == i);
    end
  end

  always_comb begin
    periodic_d = periodic_q;
    trigger_d  = '0;
    irq_d      = irq_q & ~irq_clear;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      reload_d[i] = reload_q[i];
      if (wr_hit[i]) begin
        count_d[i]    = wr_value;
        reload_d[i]   = wr_value;
        periodic_d[i] = wr_periodic;
        state_d[i]    = (wr_value != '0) ? RUN : IDLE;
      end else if (state_q[i] == RUN && enable[i]) begin
        if (count_q[i] > WIDTH'(1)) begin
          count_d[i] = count_q[i] - WIDTH'(1);
        end else begin
          // Expiry: set of irq overrides a same-cycle clear.
          trigger_d[i] = 1'b1;
          irq_d[i]     = 1'b1;
          if (periodic_q[i]) begin
            count_d[i] = reload_q[i];
          end else begin
            count_d[i] = '0;
            state_d[i] = EXPIRED;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      periodic_q <= '0;
      trigger_q  <= '0;
      irq_q      <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= IDLE;
        count_q[i]  <= '0;
        reload_q[i] <= '0;
      end
    end else begin
      periodic_q <= periodic_d;
      trigger_q  <= trigger_d;
      irq_q      <= irq_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
      end
    end
  end

  always_comb begin
    busy       = '0;
    count_flat = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      busy[i]                       = (state_q[i] == RUN);
      count_flat[i*WIDTH +: WIDTH]  = count_q[i];
    end
  end

  assign trigger = trigger_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: a default 5-bit/4-channel instance and an
// 8-bit instance with a 3-bit select for out-of-range writes and long periods.
module tb_timer_multi;

  logic        clk = 1'b0;
  logic        reset;

  logic [3:0]  en_a, clr_a, trig_a, irq_a, busy_a;
  logic        wv_a, wper_a;
  logic [1:0]  wch_a;
  logic [4:0]  wval_a;
  logic [19:0] cnt_a;

  logic [3:0]  en_b, clr_b, trig_b, irq_b, busy_b;
  logic        wv_b, wper_b;
  logic [2:0]  wch_b;
  logic [7:0]  wval_b;
  logic [31:0] cnt_b;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  timer_multi #(.WIDTH(5), .CHANNELS(4), .CH_BITS(2)) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .wr_valid(wv_a), .wr_ch(wch_a),
    .wr_value(wval_a), .wr_periodic(wper_a), .irq_clear(clr_a),
    .trigger(trig_a), .irq(irq_a), .busy(busy_a), .count_flat(cnt_a)
  );

  timer_multi #(.WIDTH(8), .CHANNELS(4), .CH_BITS(3)) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .wr_valid(wv_b), .wr_ch(wch_b),
    .wr_value(wval_b), .wr_periodic(wper_b), .irq_clear(clr_b),
    .trigger(trig_b), .irq(irq_b), .busy(busy_b), .count_flat(cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] cnt(input int ch);
    return cnt_a[ch*5 +: 5];
  endfunction

  task automatic wr_a(input logic [1:0] ch, input logic [4:0] val, input logic per);
    wv_a = 1'b1; wch_a = ch; wval_a = val; wper_a = per;
    tick();
    wv_a = 1'b0;
  endtask

  task automatic wr_b(input logic [2:0] ch, input logic [7:0] val, input logic per);
    wv_b = 1'b1; wch_b = ch; wval_b = val; wper_b = per;
    tick();
    wv_b = 1'b0;
  endtask

  initial begin
    int ntrig, first_k, second_k;
    reset = 1'b1;
    en_a = '0; clr_a = '0; wv_a = 1'b0; wch_a = '0; wval_a = '0; wper_a = 1'b0;
    en_b = '0; clr_b = '0; wv_b = 1'b0; wch_b = '0; wval_b = '0; wper_b = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_count", 32'(cnt_a), 32'h0);
    chk("rst_trig",  32'(trig_a), 32'h0);
    chk("rst_irq",   32'(irq_a), 32'h0);
    chk("rst_busy",  32'(busy_a), 32'h0);

    // Asynchronous reset mid-cycle with ch0 holding 7 and ch2 just expired
    en_a = 4'b0100;
    wr_a(2'd0, 5'd7, 1'b0);
    wr_a(2'd2, 5'd1, 1'b0);
    tick();
    chk("pre_rst_cnt0", 32'(cnt(0)), 32'd7);
    chk("pre_rst_trig", 32'(trig_a), 32'h4);
    chk("pre_rst_irq",  32'(irq_a), 32'h4);
    chk("pre_rst_busy", 32'(busy_a), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(cnt_a), 32'h0);
    chk("async_rst_trig",  32'(trig_a), 32'h0);
    chk("async_rst_irq",   32'(irq_a), 32'h0);
    chk("async_rst_busy",  32'(busy_a), 32'h0);
    #1 reset = 1'b0;
    en_a = '0;

    // One-shot on ch1
    en_a = 4'b0010;
    wr_a(2'd1, 5'd3, 1'b0);
    chk("os_load", 32'(cnt(1)), 32'd3);
    chk("os_busy0", 32'(busy_a[1]), 32'd1);
    tick(); chk("os_c2", 32'(cnt(1)), 32'd2);
    tick(); chk("os_c1", 32'(cnt(1)), 32'd1); chk("os_trig_early", 32'(trig_a), 32'h0);
    tick();
    chk("os_c0", 32'(cnt(1)), 32'd0);
    chk("os_trig", 32'(trig_a), 32'h2);
    chk("os_irq", 32'(irq_a), 32'h2);
    chk("os_busy_off", 32'(busy_a[1]), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("os_hold_cnt", 32'(cnt(1)), 32'd0);
      chk("os_hold_trig", 32'(trig_a), 32'h0);
    end
    clr_a = 4'b0010; tick(); clr_a = '0;
    chk("os_irq_clr", 32'(irq_a), 32'h0);

    // Periodic on ch2, reload 4
    en_a = 4'b0100;
    wr_a(2'd2, 5'd4, 1'b1);
    chk("per_load", 32'(cnt(2)), 32'd4);
    ntrig = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("per_cnt", 32'(cnt(2)), (k % 4 == 0) ? 32'd4 : 32'(4 - (k % 4)));
      chk("per_trig", 32'(trig_a[2]), (k % 4 == 0) ? 32'd1 : 32'd0);
      chk("per_busy", 32'(busy_a[2]), 32'd1);
      if (trig_a[2]) ntrig++;
    end
    chk("per_ntrig", 32'(ntrig), 32'd3);

    // Zero write parks the channel in IDLE; enable has no effect
    wr_a(2'd2, 5'd0, 1'b1);
    chk("zero_busy", 32'(busy_a[2]), 32'd0);
    chk("zero_cnt", 32'(cnt(2)), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("zero_notrig", 32'(trig_a[2]), 32'd0);
    end
    clr_a = 4'b0100; tick(); clr_a = '0;
    en_a = '0;

    // Enable gating and rewrite priority on ch0
    en_a = 4'b0001;
    wr_a(2'd0, 5'd5, 1'b0);
    tick(); tick();
    chk("gate_pre", 32'(cnt(0)), 32'd3);
    en_a = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("gate_hold", 32'(cnt(0)), 32'd3);
      chk("gate_busy", 32'(busy_a[0]), 32'd1);
    end
    en_a = 4'b0001;
    tick(); tick();
    chk("rw_pre", 32'(cnt(0)), 32'd1);
    wr_a(2'd0, 5'd2, 1'b0);
    chk("rw_cnt", 32'(cnt(0)), 32'd2);
    chk("rw_notrig", 32'(trig_a), 32'h0);
    chk("rw_noirq", 32'(irq_a[0]), 32'd0);
    tick(); tick();
    chk("rw_expire", 32'(trig_a), 32'h1);
    en_a = '0;

    // irq set/clear collision on ch3
    en_a = 4'b1000;
    wr_a(2'd3, 5'd2, 1'b0);
    tick();
    chk("col_pre_cnt", 32'(cnt(3)), 32'd1);
    clr_a = 4'b1000;
    tick();
    clr_a = '0;
    chk("col_trig", 32'(trig_a[3]), 32'd1);
    chk("col_irq", 32'(irq_a[3]), 32'd1);
    tick();
    chk("col_irq_hold", 32'(irq_a[3]), 32'd1);
    clr_a = 4'b1000; tick(); clr_a = '0;
    chk("col_irq_clr", 32'(irq_a[3]), 32'd0);
    en_a = '0;

    // Wide instance: out-of-range write is ignored
    wr_b(3'd1, 8'd9, 1'b0);
    wr_b(3'd5, 8'd20, 1'b1);
    chk("oor_cnt", cnt_b, 32'h0000_0900);
    chk("oor_busy", 32'(busy_b), 32'h2);

    // Wide instance: periodic 255
    en_b = 4'b0001;
    wr_b(3'd0, 8'd255, 1'b1);
    chk("p255_load", 32'(cnt_b[7:0]), 32'd255);
    ntrig = 0; first_k = 0; second_k = 0;
    for (int k = 1; k <= 510; k++) begin
      tick();
      if (k == 1) chk("p255_c1", 32'(cnt_b[7:0]), 32'd254);
      if (k == 255) chk("p255_reload", 32'(cnt_b[7:0]), 32'd255);
      if (trig_b[0]) begin
        ntrig++;
        if (ntrig == 1) first_k = k;
        if (ntrig == 2) second_k = k;
      end
    end
    chk("p255_first", 32'(first_k), 32'd255);
    chk("p255_second", 32'(second_k), 32'd510);
    chk("p255_ntrig", 32'(ntrig), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
